fsqrt_inv_arb: RTL

Round-robin arbiter and sequencer that shares one combinational `fsqrt_inv` unit (y = 1/sqrt(x), IEEE-754 single) between `NREQ` requesters. It sits in the FPU between the issue ports that need reciprocal square root and the single `fsqrt_inv` instance. It registers the winning operand, waits a fixed `LAT`-cycle multicycle window for the unit to settle, and captures the result. It then returns the result to the winner over a valid/ready handshake.

---
 rtl/fsqrt_inv_arb.sv | 123 ++++++++++++
 1 files changed

// File: rtl/fsqrt_inv_arb.sv
// Round-robin arbiter that time-shares one combinational fsqrt_inv unit among NREQ requesters.
// It runs one operation at a time: grant, wait LAT cycles, capture, then hand the result back.
module fsqrt_inv_arb #(
    parameter int NREQ = 2,
    parameter int LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_x,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    output logic [31:0]          resp_y,
    input  logic [NREQ-1:0]      resp_ready,
    output logic [31:0]          su_x,
    input  logic [31:0]          su_y
);
    localparam int GW = $clog2(NREQ);
    localparam int SW = GW + 1;
    localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [31:0]     su_x_q, su_x_d;
    logic [31:0]     res_q, res_d;
    logic [NREQ-1:0] resp_valid_q, resp_valid_d;

    logic [31:0]     x_arr [NREQ];
    logic [GW-1:0]   win;
    logic            found;
    logic [SW-1:0]   scan;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign x_arr[i] = req_x[32*i +: 32];
    end

    // Scan ptr, ptr+1, ... with wrap at NREQ; the first requester found wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        scan  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr_q} + SW'(k);
            if (scan >= SW'(NREQ)) scan = scan - SW'(NREQ);
            if (!found && req_valid[scan[GW-1:0]]) begin
                win   = scan[GW-1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && found) req_ready[win] = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        su_x_d       = su_x_q;
        res_d        = res_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    su_x_d  = x_arr[win];
                    gnt_d   = win;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 2'd0) begin
                    res_d               = su_y;
                    resp_valid_d        = '0;
                    resp_valid_d[gnt_q] = 1'b1;
                    state_d             = DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            DONE: begin
                // Returning to IDLE first keeps the next grant off the handshake path.
                if (resp_ready[gnt_q]) begin
                    resp_valid_d = '0;
                    ptr_d        = (gnt_q == GW'(NREQ - 1)) ? '0 : gnt_q + GW'(1);
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            ptr_q        <= '0;
            cnt_q        <= '0;
            su_x_q       <= '0;
            res_q        <= '0;
            resp_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            su_x_q       <= su_x_d;
            res_q        <= res_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign su_x       = su_x_q;
    assign resp_y     = res_q;
    assign resp_valid = resp_valid_q;
endmodule
